// File: rtl/fft8_frame_loader.sv
// Ping-pong frame assembler feeding an 8-point FFT core: serial samples in, 8 registered slots out.
// 8th sample -> fft_start two cycles later; s_ready drops only while both buffers await the FFT.
module fft8_frame_loader #(
  parameter int DATA_W      = 16,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              fft_start,
  input  logic              fft_done,
  output logic [DATA_W-1:0] frame_out0,
  output logic [DATA_W-1:0] frame_out1,
  output logic [DATA_W-1:0] frame_out2,
  output logic [DATA_W-1:0] frame_out3,
  output logic [DATA_W-1:0] frame_out4,
  output logic [DATA_W-1:0] frame_out5,
  output logic [DATA_W-1:0] frame_out6,
  output logic [DATA_W-1:0] frame_out7,
  output logic              busy,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [1:0][7:0][DATA_W-1:0]   buf_q, buf_d;
  logic [7:0][DATA_W-1:0]        frame_q, frame_d;
  logic [1:0]                    full_q, full_d, full_set, full_clr;
  logic                          wr_sel_q, wr_sel_d;
  logic                          rd_sel_q, rd_sel_d;
  logic [2:0]                    wr_ptr_q, wr_ptr_d;
  logic [7:0]                    frame_count_q, frame_count_d;
  logic                          load;
  logic                          wr_fire;

  function automatic logic [2:0] slot_of(input logic [2:0] p);
    return BIT_REVERSE ? {p[0], p[1], p[2]} : p;
  endfunction

  // Ready depends only on registered state so upstream never sees a valid->ready loop.
  assign s_ready = ~full_q[wr_sel_q];
  assign wr_fire = s_valid & s_ready;

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    wr_sel_d = wr_sel_q;
    full_set = '0;
    if (wr_fire) begin
      buf_d[wr_sel_q][slot_of(wr_ptr_q)] = s_data;
      wr_ptr_d = wr_ptr_q + 3'd1;
      if (wr_ptr_q == 3'd7) begin
        full_set[wr_sel_q] = 1'b1;
        wr_sel_d           = ~wr_sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_sel_d = rd_sel_q;
    full_clr = '0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_sel_q]) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (fft_done) begin
          full_clr[rd_sel_q] = 1'b1;
          rd_sel_d           = ~rd_sel_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fft_start = (state_q == START);
    busy      = (state_q == START) || (state_q == WAIT);
  end

  // Set and clear never target the same buffer: a full buffer is not writable.
  always_comb begin
    full_d        = (full_q | full_set) & ~full_clr;
    frame_d       = load ? buf_q[rd_sel_q] : frame_q;
    frame_count_d = (state_q == START) ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q         <= '0;
      frame_q       <= '0;
      full_q        <= '0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      wr_ptr_q      <= 3'd0;
      frame_count_q <= 8'd0;
    end else begin
      buf_q         <= buf_d;
      frame_q       <= frame_d;
      full_q        <= full_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_out0  = frame_q[0];
  assign frame_out1  = frame_q[1];
  assign frame_out2  = frame_q[2];
  assign frame_out3  = frame_q[3];
  assign frame_out4  = frame_q[4];
  assign frame_out5  = frame_q[5];
  assign frame_out6  = frame_q[6];
  assign frame_out7  = frame_q[7];
  assign frame_count = frame_count_q;

endmodule

// File: doc/fft8_frame_loader.md
Name: fft8_frame_loader

Overview:
- Upstream feeder for the 8-point FFT core.
- Accepts a serial stream of signed samples over a valid/ready handshake and assembles them into 8-sample frames in a ping-pong buffer.
- Presents each completed frame on eight parallel registered outputs, then pulses fft_start for one cycle and waits for the core's done before issuing the next frame.
- Optionally stores samples in bit-reversed order for decimation-in-time input.

Parameters:
- DATA_W, 16, sample width (two's complement), applied to s_data and every frame_out.
- BIT_REVERSE, 0. When 0, sample k goes to slot k. When 1, sample k goes to slot bitrev3(k).

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  loader can accept a sample.
- s_data  in  DATA_W  signed sample.
- fft_start  out  1  one-cycle start pulse to the FFT core.
- fft_done  in  1  FFT core completion; level or pulse.
- frame_out0..frame_out7  out  DATA_W each  registered frame slots 0..7 to the FFT data_in0..7.
- busy  out  1  high from the fft_start cycle until the fft_done cycle, inclusive.
- frame_count  out  8  number of frames issued; wraps 255 -> 0.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - full[1:0]=0, wr_sel=0, rd_sel=0, wr_ptr=0, FSM=IDLE.
  - fft_start=0, busy=0, frame_count=0, all frame_out=0.
  - Any partially filled frame is discarded. Reset mid-frame or mid-FFT aborts silently.
- Storage: two 8 x DATA_W buffers (buf0, buf1).
  - full[i] is set when buffer i holds 8 samples and cleared when the FFT releases it.
  - A buffer is never written while its full flag is set.
- Write side:
  - s_ready = ~full[wr_sel] (combinational from registers, never from s_valid).
  - Handshake when s_valid & s_ready: buf[wr_sel][slot(wr_ptr)] <= s_data, then wr_ptr++.
  - slot(p) = p, or bitrev3(p) when BIT_REVERSE=1.
  - On the handshake with wr_ptr==7: full[wr_sel]<=1, wr_sel toggles, wr_ptr<=0.
  - If s_valid is low, wr_ptr holds. Gaps are allowed anywhere in a frame.
- Read FSM:
  - IDLE: if full[rd_sel], load frame_out0..7 <= buf[rd_sel][0..7] and go to START.
  - START: fft_start=1 for exactly this cycle; busy=1; frame_count++; go to WAIT.
  - WAIT: busy=1. On fft_done: full[rd_sel]<=0, rd_sel toggles, go to IDLE.
  - fft_done is ignored in IDLE and START.
- Latency:
  - 8th-sample handshake in cycle N -> fft_start high in cycle N+2, provided the FFT is idle.
  - fft_done in cycle D, with the other buffer full -> next fft_start in cycle D+2.
- Output stability: frame_out holds its value from load until the next IDLE->START load, including after done.
- Backpressure:
  - Both buffers full -> s_ready=0.
  - s_ready returns to 1 in cycle D+1 after fft_done in cycle D frees the buffer.
- Simultaneous events: a write completing buffer A and fft_done releasing buffer B in the same cycle are independent; both take effect.
- Arithmetic: none. Samples pass through bit-exact with no sign extension or truncation.

Test Plan:
- Bypass order: BIT_REVERSE=0; after reset, 8 back-to-back samples 0x0100..0x0800, 8th handshake in cycle N.
  -> fft_start high only in N+2; frame_out0..7 = 0100,0200,...,0800; busy high until fft_done; frame_count=1.
- Bit-reversed order: BIT_REVERSE=1, same stimulus.
  -> frame_out0..7 = 0100,0500,0300,0700,0200,0600,0400,0800.
- Ping-pong backpressure: 24 continuous samples; fft_done returned 20 cycles after each fft_start.
  -> s_ready=0 after the 16th handshake until the cycle after the first fft_done.
  -> 2nd fft_start at D+2; frame_count=3 at the end; no sample lost or duplicated.
- Sparse input: s_valid toggles 1-0-0-1 pattern with 16-bit values 0xFFFF and 0x8000 mixed in.
  -> frame slots hold exact values; fft_start issued only after the 8th accepted sample.
- Reset mid-operation: rst after 5 samples, and separately rst in WAIT.
  -> outputs return to 0, no fft_start, frame_count=0; the next 8 samples form a clean frame starting at slot 0.
- Spurious done and wrap: pulse fft_done while IDLE -> no state change. Run 256 frames -> frame_count wraps to 0.
